// File: rtl/riscv_ifu_align.sv
// riscv_ifu_align: turns 32-bit fetch words into aligned 16/32-bit RISC-V instructions.
//   clock, reset         : sole clock, asynchronous active-high reset
//   req_vld/addr/ack     : word-aligned fetch request channel
//   rsp_vld/addr/data/ack: fetch response channel (rsp_addr informational only)
//   redirect_vld/addr    : flush buffer and refetch from a new PC
//   ifu_vld/rdy/addr/data/compressed: aligned instruction output
module riscv_ifu_align #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0200,
   parameter int          DEPTH_HW        = 8,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        req_vld,
   output logic [31:0] req_addr,
   input  logic        req_ack,
   input  logic        rsp_vld,
   input  logic [31:0] rsp_addr,
   input  logic [31:0] rsp_data,
   output logic        rsp_ack,
   input  logic        redirect_vld,
   input  logic [31:0] redirect_addr,
   output logic        ifu_vld,
   input  logic        ifu_rdy,
   output logic [31:0] ifu_addr,
   output logic [31:0] ifu_data,
   output logic        ifu_compressed
);
   localparam int AW = $clog2(DEPTH_HW);
   localparam logic [AW:0] ONE = 1;
   localparam logic [AW:0] TWO = 2;
   logic [15:0] hw_data [DEPTH_HW];
   logic [31:0] hw_addr [DEPTH_HW];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
   logic [AW:0] count, n_push, n_pop;
   logic [2:0] outstanding, stale, out_next;
   logic [31:0] fetch_pc, rsp_pc;
   logic skip_first, req_hs, rsp_take, rsp_drop, push, pop, head_comp;
   logic [15:0] head, head1;
   logic unused;
   assign unused = ^{rsp_addr, redirect_addr[0]};
   assign rd_nxt = rd_ptr + AW'(1);
   assign wr_nxt = wr_ptr + AW'(1);
   // every in-flight request reserves two halfwords, so pushes never overflow
   assign req_vld = !reset && !redirect_vld && (int'(outstanding) < MAX_OUTSTANDING) &&
                    (int'(count) + 2 * int'(outstanding) + 2 <= DEPTH_HW);
   assign req_addr = {fetch_pc[31:2], 2'b00};
   assign req_hs = req_vld && req_ack;
   assign rsp_ack = rsp_vld;
   assign rsp_take = rsp_vld && (outstanding != 3'd0);
   // a response landing in the redirect cycle belongs to the old stream
   assign rsp_drop = rsp_take && (stale != 3'd0 || redirect_vld);
   assign push = rsp_take && !rsp_drop;
   assign out_next = outstanding + {2'b00, req_hs} - {2'b00, rsp_take};
   assign head = hw_data[rd_ptr];
   assign head1 = hw_data[rd_nxt];
   assign head_comp = head[1:0] != 2'b11;
   assign ifu_vld = !redirect_vld && (count != '0) && (head_comp || count[AW:1] != '0);
   assign ifu_compressed = ifu_vld && head_comp;
   assign ifu_addr = ifu_vld ? hw_addr[rd_ptr] : '0;
   assign ifu_data = !ifu_vld ? '0 : head_comp ? {16'h0000, head} : {head1, head};
   assign pop = ifu_vld && ifu_rdy;
   assign n_pop = !pop ? '0 : head_comp ? ONE : TWO;
   assign n_push = !push ? '0 : skip_first ? ONE : TWO;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         outstanding <= '0;
         stale       <= '0;
         skip_first  <= 1'b0;
      end else if (redirect_vld) begin
         fetch_pc    <= {redirect_addr[31:2], 2'b00};
         rsp_pc      <= {redirect_addr[31:2], 2'b00};
         skip_first  <= redirect_addr[1];
         stale       <= out_next;
         outstanding <= out_next;
         count       <= '0;
         rd_ptr      <= wr_ptr;
      end else begin
         if (req_hs) fetch_pc <= fetch_pc + 32'd4;
         if (push) begin
            rsp_pc     <= rsp_pc + 32'd4;
            skip_first <= 1'b0;
         end
         if (rsp_drop) stale <= stale - 3'd1;
         outstanding <= out_next;
         count       <= count + n_push - n_pop;
         rd_ptr      <= rd_ptr + n_pop[AW-1:0];
         wr_ptr      <= wr_ptr + n_push[AW-1:0];
      end
   // storage needs no reset: count gates every read
   always_ff @(posedge clock)
      if (push) begin
         hw_data[wr_ptr] <= skip_first ? rsp_data[31:16] : rsp_data[15:0];
         hw_addr[wr_ptr] <= skip_first ? rsp_pc + 32'd2 : rsp_pc;
         if (!skip_first) begin
            hw_data[wr_nxt] <= rsp_data[31:16];
            hw_addr[wr_nxt] <= rsp_pc + 32'd2;
         end
      end
endmodule

// File: tb/tb_riscv_ifu_align.sv
// tb_riscv_ifu_align: directed checks of the fetch aligner against a small memory responder.
module tb_riscv_ifu_align;
   logic clock = 1'b0, reset = 1'b1;
   logic req_vld, req_ack = 1'b1, rsp_vld = 1'b0, rsp_ack, redirect_vld = 1'b0;
   logic ifu_vld, ifu_rdy = 1'b1, ifu_compressed;
   logic [31:0] req_addr, rsp_addr = '0, rsp_data = '0, redirect_addr = '0, ifu_addr, ifu_data;
   logic rsp_en = 1'b1;
   int n_chk = 0, n_err = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] pend [$];
   logic [31:0] reqs [$];
   logic [64:0] caps [$];
   always #5 clock = ~clock;
   riscv_ifu_align dut (
      .clock(clock), .reset(reset),
      .req_vld(req_vld), .req_addr(req_addr), .req_ack(req_ack),
      .rsp_vld(rsp_vld), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
      .redirect_vld(redirect_vld), .redirect_addr(redirect_addr),
      .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy), .ifu_addr(ifu_addr),
      .ifu_data(ifu_data), .ifu_compressed(ifu_compressed)
   );
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0000_0013;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // memory: answers each accepted request one cycle later, in order
   initial forever begin
      @(negedge clock);
      if (req_vld && req_ack) begin
         pend.push_back(req_addr);
         reqs.push_back(req_addr);
      end
      if (ifu_vld && ifu_rdy) caps.push_back({ifu_addr, ifu_data, ifu_compressed});
      @(posedge clock);
      #1;
      if (reset) pend.delete();
      if (rsp_en && !reset && pend.size() > 0) begin
         rsp_vld  = 1'b1;
         rsp_addr = pend[0];
         rsp_data = mem_rd(pend.pop_front());
      end else rsp_vld = 1'b0;
   end
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      pend.delete();
      reqs.delete();
      caps.delete();
      rsp_vld = 1'b0;
      redirect_vld = 1'b0;
      rsp_en = 1'b1;
      reset = 1'b0;
   endtask
   task automatic wait_caps(input int n);
      for (int i = 0; i < 100 && caps.size() < n; i++) @(posedge clock);
      chk("wait_instructions", caps.size() >= n, 1);
   endtask
   task automatic chk_ins(input int i, input logic [31:0] a, input logic [31:0] d, input logic c);
      logic [64:0] e;
      e = (i < caps.size()) ? caps[i] : '1;
      chk($sformatf("ins%0d_addr", i), e[64:33], a);
      chk($sformatf("ins%0d_data", i), e[32:1], d);
      chk($sformatf("ins%0d_comp", i), {31'd0, e[0]}, {31'd0, c});
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      #2;
      chk("rst_req_vld", req_vld, 0);
      chk("rst_ifu_vld", ifu_vld, 0);
      chk("rst_ifu_addr", ifu_addr, 0);
      // two 32-bit instructions
      mem[32'h200] = 32'h0000_0013;
      mem[32'h204] = 32'h0010_0093;
      do_reset();
      @(negedge clock);
      chk("first_req_vld", req_vld, 1);
      chk("first_req_addr", req_addr, 32'h200);
      wait_caps(2);
      chk_ins(0, 32'h200, 32'h0000_0013, 0);
      chk_ins(1, 32'h204, 32'h0010_0093, 0);
      // two compressed instructions in one word
      mem.delete();
      mem[32'h200] = 32'h4501_4501;
      do_reset();
      wait_caps(3);
      chk_ins(0, 32'h200, 32'h0000_4501, 1);
      chk_ins(1, 32'h202, 32'h0000_4501, 1);
      chk_ins(2, 32'h204, 32'h0000_0013, 0);
      // 32-bit instruction straddling two words
      mem.delete();
      mem[32'h200] = 32'h0013_4501;
      mem[32'h204] = 32'h4501_0000;
      do_reset();
      wait_caps(4);
      chk_ins(0, 32'h200, 32'h0000_4501, 1);
      chk_ins(1, 32'h202, 32'h0000_0013, 0);
      chk_ins(2, 32'h206, 32'h0000_4501, 1);
      chk_ins(3, 32'h208, 32'h0000_0013, 0);
      // misaligned 32-bit stream crossing the buffer wrap point
      mem.delete();
      mem[32'h200] = 32'h0013_4501;
      for (int k = 1; k <= 10; k++) mem[32'h200 + 4 * k] = 32'h0013_0000;
      do_reset();
      wait_caps(7);
      chk_ins(0, 32'h200, 32'h0000_4501, 1);
      for (int k = 1; k <= 6; k++) chk_ins(k, 32'h202 + 4 * (k - 1), 32'h0000_0013, 0);
      // consumer stall for 20 cycles
      mem.delete();
      ifu_rdy = 1'b0;
      do_reset();
      repeat (5) @(negedge clock);
      chk("stall_vld_a", ifu_vld, 1);
      chk("stall_addr_a", ifu_addr, 32'h200);
      chk("stall_data_a", ifu_data, 32'h13);
      repeat (15) @(negedge clock);
      chk("stall_vld_b", ifu_vld, 1);
      chk("stall_addr_b", ifu_addr, 32'h200);
      chk("stall_data_b", ifu_data, 32'h13);
      chk("stall_req_vld", req_vld, 0);
      chk("stall_req_count", reqs.size(), 4);
      ifu_rdy = 1'b1;
      wait_caps(6);
      for (int k = 0; k < 6; k++) chk_ins(k, 32'h200 + 4 * k, 32'h0000_0013, 0);
      // redirect with two responses in flight
      mem.delete();
      mem[32'h200] = 32'h4501_4501;
      mem[32'h204] = 32'h4501_4501;
      mem[32'h1000] = 32'h0013_4501;
      mem[32'h1004] = 32'h1234_0000;
      do_reset();
      rsp_en = 1'b0;
      for (int i = 0; i < 20 && reqs.size() < 2; i++) @(negedge clock);
      chk("redir_two_reqs", reqs.size(), 2);
      @(negedge clock);
      chk("redir_credit_stop", req_vld, 0);
      redirect_vld = 1'b1;
      redirect_addr = 32'h1002;
      @(negedge clock);
      redirect_vld = 1'b0;
      rsp_en = 1'b1;
      reqs.delete();
      wait_caps(2);
      chk("redir_req_addr", (reqs.size() > 0) ? reqs[0] : '1, 32'h1000);
      chk_ins(0, 32'h1002, 32'h0000_0013, 0);
      chk_ins(1, 32'h1006, 32'h0000_1234, 1);
      // asynchronous reset while busy
      mem.delete();
      ifu_rdy = 1'b0;
      do_reset();
      repeat (6) @(negedge clock);
      chk("busy_ifu_vld", ifu_vld, 1);
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_req_vld", req_vld, 0);
      chk("arst_ifu_vld", ifu_vld, 0);
      chk("arst_ifu_addr", ifu_addr, 0);
      chk("arst_ifu_data", ifu_data, 0);
      chk("arst_ifu_comp", ifu_compressed, 0);
      ifu_rdy = 1'b1;
      do_reset();
      @(negedge clock);
      chk("arst_first_req", req_addr, 32'h200);
      wait_caps(1);
      chk_ins(0, 32'h200, 32'h0000_0013, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
